// File: rtl/axis_switch_splitter_pkg.sv
// Shared definitions for the N-port AXI-Stream packet splitter: register map, modes, FSM states.
package axis_switch_splitter_pkg;

  localparam logic [6:0] REG_DEST_SEL     = 7'h00;
  localparam logic [6:0] REG_MODE         = 7'h04;
  localparam logic [6:0] REG_STATUS       = 7'h08;
  localparam logic [6:0] REG_CLEAR        = 7'h0C;
  localparam logic [6:0] REG_PKT_CNT_BASE = 7'h10;
  localparam logic [6:0] REG_DROP_CNT     = 7'h50;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_TUSER  = 2'd1,
    MODE_BCAST  = 2'd2
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

endpackage

// File: rtl/axis_switch_splitter_regs.sv
// AXI-lite control slave: DEST_SEL/MODE registers, STATUS, per-port packet and drop counters.
// MODE = 2 (broadcast) is only accepted when SPLITTER_BROADCAST_EN is defined.
module axis_switch_splitter_regs
  import axis_switch_splitter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEST_W    = 2
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_axi_ctrl_awvalid,
  output logic                 s_axi_ctrl_awready,
  input  logic [6:0]           s_axi_ctrl_awaddr,
  input  logic                 s_axi_ctrl_wvalid,
  output logic                 s_axi_ctrl_wready,
  input  logic [31:0]          s_axi_ctrl_wdata,
  input  logic [3:0]           s_axi_ctrl_wstrb,
  output logic                 s_axi_ctrl_bvalid,
  input  logic                 s_axi_ctrl_bready,
  output logic [1:0]           s_axi_ctrl_bresp,
  input  logic                 s_axi_ctrl_arvalid,
  output logic                 s_axi_ctrl_arready,
  input  logic [6:0]           s_axi_ctrl_araddr,
  output logic                 s_axi_ctrl_rvalid,
  input  logic                 s_axi_ctrl_rready,
  output logic [31:0]          s_axi_ctrl_rdata,
  output logic [1:0]           s_axi_ctrl_rresp,
  output logic [DEST_W-1:0]    dest_sel,
  output mode_e                mode,
  input  logic                 busy,
  input  logic [DEST_W-1:0]    cur_dest,
  input  logic [NUM_PORTS-1:0] pkt_inc,
  input  logic                 drop_inc
);

  logic        wr_en_c;
  logic        rd_en_c;
  logic        clear_c;
  logic        mode_ok_c;
  logic [31:0] rd_data_c;
  logic [31:0] pkt_cnt_q [NUM_PORTS];
  logic [31:0] drop_cnt_q;
  logic        unused_c;

  function automatic logic addr_mapped(input logic [6:0] addr);
    logic hit;
    hit = (addr == REG_DEST_SEL) || (addr == REG_MODE) || (addr == REG_STATUS) ||
          (addr == REG_CLEAR) || (addr == REG_DROP_CNT);
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      if (addr == REG_PKT_CNT_BASE + 7'(4 * i)) hit = 1'b1;
    return hit;
  endfunction

  assign wr_en_c            = s_axi_ctrl_awvalid & s_axi_ctrl_wvalid & ~s_axi_ctrl_bvalid & ~areset;
  assign s_axi_ctrl_awready = wr_en_c;
  assign s_axi_ctrl_wready  = wr_en_c;
  assign s_axi_ctrl_arready = ~s_axi_ctrl_rvalid & ~areset;
  assign rd_en_c            = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
  assign clear_c            = wr_en_c && (s_axi_ctrl_awaddr == REG_CLEAR) && s_axi_ctrl_wdata[0];
  assign unused_c           = ^{s_axi_ctrl_wstrb, s_axi_ctrl_wdata};

  // Reserved and disabled modes are silently rejected.
  always_comb begin
    mode_ok_c = 1'b0;
    case (s_axi_ctrl_wdata[1:0])
      MODE_STATIC, MODE_TUSER: mode_ok_c = 1'b1;
`ifdef SPLITTER_BROADCAST_EN
      MODE_BCAST:              mode_ok_c = 1'b1;
`endif
      default:                 mode_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      dest_sel          <= '0;
      mode              <= MODE_STATIC;
      s_axi_ctrl_bvalid <= 1'b0;
      s_axi_ctrl_bresp  <= RESP_OKAY;
    end else if (wr_en_c) begin
      s_axi_ctrl_bvalid <= 1'b1;
      s_axi_ctrl_bresp  <= addr_mapped(s_axi_ctrl_awaddr) ? RESP_OKAY : RESP_SLVERR;
      if (s_axi_ctrl_awaddr == REG_DEST_SEL) dest_sel <= s_axi_ctrl_wdata[DEST_W-1:0];
      if ((s_axi_ctrl_awaddr == REG_MODE) && mode_ok_c) mode <= mode_e'(s_axi_ctrl_wdata[1:0]);
    end else if (s_axi_ctrl_bready) begin
      s_axi_ctrl_bvalid <= 1'b0;
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge aclk) begin
    if (areset || clear_c) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) pkt_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++)
        if (pkt_inc[i]) pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (s_axi_ctrl_araddr == REG_DEST_SEL)      rd_data_c = 32'(dest_sel);
    else if (s_axi_ctrl_araddr == REG_MODE)     rd_data_c = 32'(mode);
    else if (s_axi_ctrl_araddr == REG_STATUS)   rd_data_c = {20'd0, 4'(cur_dest), 7'd0, busy};
    else if (s_axi_ctrl_araddr == REG_DROP_CNT) rd_data_c = drop_cnt_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      if (s_axi_ctrl_araddr == REG_PKT_CNT_BASE + 7'(4 * i)) rd_data_c = pkt_cnt_q[i];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_ctrl_rvalid <= 1'b0;
      s_axi_ctrl_rdata  <= '0;
      s_axi_ctrl_rresp  <= RESP_OKAY;
    end else if (rd_en_c) begin
      s_axi_ctrl_rvalid <= 1'b1;
      s_axi_ctrl_rdata  <= rd_data_c;
      s_axi_ctrl_rresp  <= addr_mapped(s_axi_ctrl_araddr) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_ctrl_rready) begin
      s_axi_ctrl_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_switch_splitter_nport.sv
// N-port AXI-Stream packet splitter: zero-latency routing of whole packets to one output port.
// Define SPLITTER_BROADCAST_EN to enable broadcast mode (MODE = 2).
module axis_switch_splitter_nport
  import axis_switch_splitter_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 48,
  parameter int unsigned NUM_PORTS   = 4
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [TDATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]             s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]               s_axis_tuser,
  output logic [NUM_PORTS-1:0]                 m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                 m_axis_tready,
  output logic [NUM_PORTS-1:0]                 m_axis_tlast,
  output logic [NUM_PORTS*TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [NUM_PORTS*TUSER_WIDTH-1:0]     m_axis_tuser,
  input  logic                                 s_axi_ctrl_awvalid,
  output logic                                 s_axi_ctrl_awready,
  input  logic [6:0]                           s_axi_ctrl_awaddr,
  input  logic                                 s_axi_ctrl_wvalid,
  output logic                                 s_axi_ctrl_wready,
  input  logic [31:0]                          s_axi_ctrl_wdata,
  input  logic [3:0]                           s_axi_ctrl_wstrb,
  output logic                                 s_axi_ctrl_bvalid,
  input  logic                                 s_axi_ctrl_bready,
  output logic [1:0]                           s_axi_ctrl_bresp,
  input  logic                                 s_axi_ctrl_arvalid,
  output logic                                 s_axi_ctrl_arready,
  input  logic [6:0]                           s_axi_ctrl_araddr,
  output logic                                 s_axi_ctrl_rvalid,
  input  logic                                 s_axi_ctrl_rready,
  output logic [31:0]                          s_axi_ctrl_rdata,
  output logic [1:0]                           s_axi_ctrl_rresp
);

  localparam int unsigned DEST_W = $clog2(NUM_PORTS);

  state_e                state_q, state_d;
  logic [DEST_W-1:0]     dest_q, dest_d, dest_c;
  logic                  bcast_q, bcast_d, bcast_c;
  logic                  drop_c;
  logic                  beat_c;
  logic [DEST_W-1:0]     dest_sel;
  mode_e                 mode;
  logic [NUM_PORTS-1:0]  pkt_inc;
  logic                  drop_inc;

  // First beat takes routing from the live registers; later beats use the latched copy.
  always_comb begin
    if (state_q == PKT) begin
      dest_c  = dest_q;
      bcast_c = bcast_q;
    end else begin
      dest_c  = (mode == MODE_TUSER) ? s_axis_tuser[DEST_W-1:0] : dest_sel;
      bcast_c = (mode == MODE_BCAST);
    end
  end

  assign drop_c = ~bcast_c && (32'(dest_c) >= NUM_PORTS);

  always_comb begin
    m_axis_tvalid = '0;
    s_axis_tready = 1'b0;
    if (!areset) begin
      if (bcast_c) begin
        m_axis_tvalid = {NUM_PORTS{s_axis_tvalid}};
        s_axis_tready = &m_axis_tready;
      end else if (drop_c) begin
        s_axis_tready = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (dest_c == DEST_W'(i)) begin
            m_axis_tvalid[i] = s_axis_tvalid;
            s_axis_tready    = m_axis_tready[i];
          end
        end
      end
    end
  end

  assign beat_c       = s_axis_tvalid & s_axis_tready;
  assign m_axis_tlast = {NUM_PORTS{s_axis_tlast}};
  assign m_axis_tdata = {NUM_PORTS{s_axis_tdata}};
  assign m_axis_tkeep = {NUM_PORTS{s_axis_tkeep}};
  assign m_axis_tuser = {NUM_PORTS{s_axis_tuser}};

  always_comb begin
    pkt_inc = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      pkt_inc[i] = beat_c & s_axis_tlast & (bcast_c | (~drop_c & (dest_c == DEST_W'(i))));
  end

  assign drop_inc = beat_c & s_axis_tlast & drop_c;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    bcast_d = bcast_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && !(beat_c && s_axis_tlast)) begin
          state_d = PKT;
          dest_d  = dest_c;
          bcast_d = bcast_c;
        end
      end
      PKT: begin
        if (beat_c && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      dest_q  <= '0;
      bcast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      bcast_q <= bcast_d;
    end
  end

  axis_switch_splitter_regs #(
    .NUM_PORTS (NUM_PORTS),
    .DEST_W    (DEST_W)
  ) u_regs (
    .aclk               (aclk),
    .areset             (areset),
    .s_axi_ctrl_awvalid (s_axi_ctrl_awvalid),
    .s_axi_ctrl_awready (s_axi_ctrl_awready),
    .s_axi_ctrl_awaddr  (s_axi_ctrl_awaddr),
    .s_axi_ctrl_wvalid  (s_axi_ctrl_wvalid),
    .s_axi_ctrl_wready  (s_axi_ctrl_wready),
    .s_axi_ctrl_wdata   (s_axi_ctrl_wdata),
    .s_axi_ctrl_wstrb   (s_axi_ctrl_wstrb),
    .s_axi_ctrl_bvalid  (s_axi_ctrl_bvalid),
    .s_axi_ctrl_bready  (s_axi_ctrl_bready),
    .s_axi_ctrl_bresp   (s_axi_ctrl_bresp),
    .s_axi_ctrl_arvalid (s_axi_ctrl_arvalid),
    .s_axi_ctrl_arready (s_axi_ctrl_arready),
    .s_axi_ctrl_araddr  (s_axi_ctrl_araddr),
    .s_axi_ctrl_rvalid  (s_axi_ctrl_rvalid),
    .s_axi_ctrl_rready  (s_axi_ctrl_rready),
    .s_axi_ctrl_rdata   (s_axi_ctrl_rdata),
    .s_axi_ctrl_rresp   (s_axi_ctrl_rresp),
    .dest_sel           (dest_sel),
    .mode               (mode),
    .busy               (state_q == PKT),
    .cur_dest           (dest_q),
    .pkt_inc            (pkt_inc),
    .drop_inc           (drop_inc)
  );

endmodule

// File: tb/tb_axis_switch_splitter_nport.sv
// Bench for axis_switch_splitter_nport with 3 ports (so destination 3 exercises the drop path).
module tb_axis_switch_splitter_nport;

  localparam int TDW = 32;
  localparam int TUW = 8;
  localparam int NP  = 3;
`ifdef SPLITTER_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 areset;
  logic                 s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [TDW-1:0]       s_axis_tdata;
  logic [TDW/8-1:0]     s_axis_tkeep;
  logic [TUW-1:0]       s_axis_tuser;
  logic [NP-1:0]        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [NP*TDW-1:0]    m_axis_tdata;
  logic [NP*TDW/8-1:0]  m_axis_tkeep;
  logic [NP*TUW-1:0]    m_axis_tuser;
  logic                 awvalid, awready, wvalid, wready, bvalid, bready;
  logic [6:0]           awaddr, araddr;
  logic [31:0]          wdata, rdata;
  logic [3:0]           wstrb;
  logic [1:0]           bresp, rresp;
  logic                 arvalid, arready, rvalid, rready;

  int checks = 0;
  int failures = 0;

  // Reference model state (updated on the falling edge for the coming rising edge)
  int          m_dest_sel, m_mode, m_pkt_dest;
  bit          m_in_pkt, m_pkt_bcast;
  int unsigned m_cnt [NP];
  int unsigned m_drop;
  int          exp_beats [NP];
  int          got_beats [NP];

  always #5 clk = ~clk;

  axis_switch_splitter_nport #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .NUM_PORTS(NP)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
    .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
    .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Compare process plus model update, once per cycle
  always @(negedge clk) begin
    logic [NP-1:0] ev;
    logic          er, pay_ok;
    int            d;
    bit            bc;
    if (areset) begin
      chk("reset_outputs", 32'({m_axis_tvalid, s_axis_tready, awready, arready, bvalid, rvalid}), 32'd0);
      m_dest_sel = 0; m_mode = 0; m_in_pkt = 0; m_pkt_dest = 0; m_pkt_bcast = 0; m_drop = 0;
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    end else begin
      d  = m_in_pkt ? m_pkt_dest : ((m_mode == 1) ? int'(s_axis_tuser[1:0]) : m_dest_sel);
      bc = m_in_pkt ? m_pkt_bcast : (m_mode == 2);
      ev = '0;
      er = 1'b0;
      if (bc) begin
        ev = {NP{s_axis_tvalid}};
        er = &m_axis_tready;
      end else if (d >= NP) begin
        er = 1'b1;
      end else begin
        ev[d] = s_axis_tvalid;
        er    = m_axis_tready[d];
      end
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
      chk("s_tready", 32'(s_axis_tready), 32'(er));
      pay_ok = 1'b1;
      for (int i = 0; i < NP; i++)
        if (m_axis_tdata[i*TDW +: TDW] !== s_axis_tdata || m_axis_tkeep[i*4 +: 4] !== s_axis_tkeep ||
            m_axis_tuser[i*TUW +: TUW] !== s_axis_tuser || m_axis_tlast[i] !== s_axis_tlast)
          pay_ok = 1'b0;
      chk("payload_bcast", 32'(pay_ok), 32'd1);
      for (int i = 0; i < NP; i++) if (m_axis_tvalid[i] && m_axis_tready[i]) got_beats[i]++;
      if (s_axis_tvalid && er) begin
        for (int i = 0; i < NP; i++) if (ev[i]) exp_beats[i]++;
        if (s_axis_tlast) begin
          m_in_pkt = 0;
          if (bc) for (int i = 0; i < NP; i++) m_cnt[i]++;
          else if (d >= NP) m_drop++;
          else m_cnt[d]++;
        end else if (!m_in_pkt) begin
          m_in_pkt = 1; m_pkt_dest = d; m_pkt_bcast = bc;
        end
      end
      if (awvalid && awready) begin
        if (awaddr == 7'h00) m_dest_sel = int'(wdata[1:0]);
        if (awaddr == 7'h04 && (wdata[1:0] < 2'd2 || (BCAST && wdata[1:0] == 2'd2)))
          m_mode = int'(wdata[1:0]);
        if (awaddr == 7'h0C && wdata[0]) begin
          m_drop = 0;
          for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        end
      end
    end
  end

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit ok;
    int n;
    resp = 2'b11;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = awready; @(posedge clk); #1; n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) timeout("aw_handshake");
    bready = 1'b1; ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; resp = bresp; end
      @(posedge clk); #1; n++;
    end
    bready = 1'b0;
    if (!ok) timeout("b_response");
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    int n;
    d = 32'hDEAD_BEEF; resp = 2'b11;
    araddr = a; arvalid = 1'b1; ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = arready; @(posedge clk); #1; n++;
    end
    arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
    rready = 1'b1; ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1; n++;
    end
    rready = 1'b0;
    if (!ok) timeout("r_response");
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, r);
    chk("wr_bresp_okay", 32'(r), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(name, d, exp);
    chk("rd_rresp_okay", 32'(r), 32'd0);
  endtask

  // Counters against the model
  task automatic chk_counters();
    for (int i = 0; i < NP; i++) rd_chk("pkt_cnt_model", 7'(16 + 4 * i), m_cnt[i]);
    rd_chk("drop_cnt_model", 7'h50, m_drop);
  endtask

  // Later beats carry a different tuser so only the first beat can steer the packet
  task automatic send_pkt(input int nbeats, input logic [7:0] tu, input logic [31:0] base);
    bit ok;
    int n;
    for (int b = 0; b < nbeats; b++) begin
      s_axis_tdata  = base + 32'(b);
      s_axis_tkeep  = 4'(4'hF >> (b % 4));
      s_axis_tuser  = (b == 0) ? tu : ~tu;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tvalid = 1'b1;
      ok = 0; n = 0;
      while (!ok && n < 200) begin
        @(negedge clk); ok = s_axis_tready; @(posedge clk); #1; n++;
      end
      if (!ok) begin timeout("stream_beat"); break; end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, dsum;
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  pat;
    for (int i = 0; i < NP; i++) begin exp_beats[i] = 0; got_beats[i] = 0; end
    areset = 1'b1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    m_axis_tready = '1;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = 4'hF; bready = 0;
    arvalid = 0; araddr = '0; rready = 0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // Reset values
    rd_chk("rst_dest_sel", 7'h00, 32'h0);
    rd_chk("rst_mode", 7'h04, 32'h0);
    rd_chk("rst_status", 7'h08, 32'h0);
    chk_counters();

    // Static mode, three 4-beat packets to port 2
    wr(7'h00, 32'd2);
    for (int p = 0; p < 3; p++) send_pkt(4, 8'h00, 32'h1000 * (p + 1));
    rd_chk("static_cnt2", 7'h18, 32'd3);
    rd_chk("static_cnt0", 7'h10, 32'd0);
    chk("static_beats2", 32'(got_beats[2]), 32'd12);

    // DEST_SEL change mid-packet applies to the next packet only
    wr(7'h00, 32'd1);
    fork
      send_pkt(5, 8'h00, 32'h2000);
      begin
        @(posedge clk); #1; @(posedge clk); #1;
        wr(7'h00, 32'd2);
      end
    join
    send_pkt(2, 8'h00, 32'h2100);
    rd_chk("midwr_cnt1", 7'h14, 32'd1);
    rd_chk("midwr_cnt2", 7'h18, 32'd4);

    // STATUS while a tuser-routed packet to port 1 is stalled
    wr(7'h04, 32'd1);
    fork
      send_pkt(3, 8'h01, 32'h3000);
      begin
        @(posedge clk); #1;
        m_axis_tready[1] = 1'b0;
        rd_chk("status_busy", 7'h08, 32'h0000_0101);
        m_axis_tready[1] = 1'b1;
      end
    join

    // Tuser routing 0, 3 (dropped), 1
    send_pkt(2, 8'h00, 32'h4000);
    send_pkt(2, 8'h03, 32'h4100);
    send_pkt(2, 8'h01, 32'h4200);
    rd_chk("tuser_cnt0", 7'h10, 32'd1);
    rd_chk("tuser_cnt1", 7'h14, 32'd3);
    rd_chk("tuser_drop", 7'h50, 32'd1);
    chk_counters();

    // Backpressure on port 0 with pattern 1,0,0,1
    wr(7'h04, 32'd0);
    wr(7'h00, 32'd0);
    d0 = got_beats[0];
    pat = 4'b1001;
    fork
      send_pkt(4, 8'h00, 32'h5000);
      begin
        for (int k = 0; k < 4; k++) begin
          m_axis_tready[0] = pat[3-k];
          @(posedge clk); #1;
        end
        m_axis_tready[0] = 1'b1;
      end
    join
    chk("bp_beats_delta", 32'(got_beats[0] - d0), 32'd4);
    for (int i = 0; i < NP; i++) chk("beats_vs_model", 32'(got_beats[i]), 32'(exp_beats[i]));
    rd_chk("bp_cnt0", 7'h10, 32'd2);

    // CLEAR coinciding with a tlast handshake on port 0
    fork
      send_pkt(1, 8'h00, 32'h6000);
      wr(7'h0C, 32'd1);
    join
    rd_chk("clear_cnt0", 7'h10, 32'd0);
    rd_chk("clear_drop", 7'h50, 32'd0);
    chk_counters();

`ifdef SPLITTER_BROADCAST_EN
    // Broadcast: a stalled port blocks every beat
    wr(7'h04, 32'd2);
    rd_chk("bcast_mode", 7'h04, 32'd2);
    m_axis_tready = 3'b101;
    dsum = got_beats[0] + got_beats[1] + got_beats[2];
    fork
      send_pkt(2, 8'h00, 32'h7000);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bcast_stalled", 32'(got_beats[0] + got_beats[1] + got_beats[2] - dsum), 32'd0);
        m_axis_tready = 3'b111;
      end
    join
    for (int i = 0; i < NP; i++) rd_chk("bcast_cnt", 7'(16 + 4 * i), 32'd1);
    wr(7'h04, 32'd0);
`else
    // Broadcast disabled: MODE 2 and 3 are ignored
    wr(7'h04, 32'd1);
    wr(7'h04, 32'd2);
    rd_chk("mode2_ignored", 7'h04, 32'd1);
    wr(7'h04, 32'd3);
    rd_chk("mode3_ignored", 7'h04, 32'd1);
    wr(7'h04, 32'd0);
    dsum = 0;
`endif

    // Unmapped accesses
    axi_read(7'h7C, d, r);
    chk("unmapped_rdata", d, 32'd0);
    chk("unmapped_rresp", 32'(r), 32'd2);
    axi_write(7'h7C, 32'hFFFF_FFFF, r);
    chk("unmapped_bresp", 32'(r), 32'd2);
    rd_chk("clear_reads_zero", 7'h0C, 32'd0);

    // Reset in the middle of a packet to port 1
    wr(7'h00, 32'd1);
    s_axis_tdata = 32'h8000; s_axis_tkeep = 4'hF; s_axis_tuser = 8'h00;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tdata = 32'h8001;
    areset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mid_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    areset = 1'b0;
    rd_chk("rst_mid_status", 7'h08, 32'd0);
    rd_chk("rst_mid_dest_sel", 7'h00, 32'd0);
    chk_counters();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
